// File: rtl/conv_kxk_stream_pkg.sv
// Shared definitions for the KxK streaming convolution block.
package conv_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } conv_state_e;

  // Cycles from the accepting clock edge to the dout_valid pulse.
  localparam int unsigned CONV_LAT = 3;

  // Signed accumulator width: full product plus growth of a KSIZE*KSIZE sum.
  function automatic int unsigned conv_accw(input int unsigned bw,
                                            input int unsigned wb,
                                            input int unsigned k);
    return bw + wb + 1 + $clog2(k * k);
  endfunction

endpackage

// File: rtl/conv_kxk_stream_if.sv
// Coefficient load, pixel stream and result bus of conv_kxk_stream.
interface conv_kxk_stream_if #(
  parameter int unsigned BITWIDTH = 8,
  parameter int unsigned WBITS    = 8
) ();
  logic                       weight_in_valid;
  logic [4:0]                 weight_addr;
  logic signed [WBITS-1:0]    weight;
  logic                       weight_commit;
  logic                       ready;
  logic                       data_in_valid;
  logic                       sof;
  logic [BITWIDTH-1:0]        din;
  logic [BITWIDTH-1:0]        dout;
  logic                       dout_valid;

  modport master (
    output weight_in_valid, weight_addr, weight, weight_commit,
    output data_in_valid, sof, din,
    input  ready, dout, dout_valid
  );

  modport slave (
    input  weight_in_valid, weight_addr, weight, weight_commit,
    input  data_in_valid, sof, din,
    output ready, dout, dout_valid
  );
endinterface

// File: rtl/conv_kxk_stream_line_buffer.sv
// DEPTH chained line delays of COLS pixels each; tap d is the pixel
// from (d+1) lines earlier in the same column.
module conv_line_buffer #(
  parameter int unsigned BITWIDTH = 8,
  parameter int unsigned COLS     = 640,
  parameter int unsigned DEPTH    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_en,
  input  logic [BITWIDTH-1:0] i_pix,
  output logic [BITWIDTH-1:0] o_taps [DEPTH]
);
  localparam int unsigned LEN = DEPTH * COLS;

  logic [BITWIDTH-1:0] r_sr [LEN];

  // Shift the whole delay line by one pixel on every accepted pixel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < LEN; i++) r_sr[i] <= '0;
    end else if (i_en) begin
      r_sr[0] <= i_pix;
      for (int unsigned i = 1; i < LEN; i++) r_sr[i] <= r_sr[i-1];
    end
  end

  // Tap the end of each COLS-long segment.
  always_comb begin
    for (int unsigned d = 0; d < DEPTH; d++) o_taps[d] = r_sr[(d + 1) * COLS - 1];
  end
endmodule

// File: rtl/conv_kxk_stream.sv
// KxK streaming "valid" convolution: line buffers, window, 3-stage
// multiply / adder-tree / shift-saturate pipeline.
// Optional build macro CONV_ROUND_EN: round half up before the shift.
module conv_kxk_stream
  import conv_pkg::*;
#(
  parameter int unsigned BITWIDTH = 8,
  parameter int unsigned WBITS    = 8,
  parameter int unsigned KSIZE    = 3,
  parameter int unsigned COLS     = 640,
  parameter int unsigned ROWS     = 480,
  parameter int unsigned SHIFT    = 7
) (
  input logic         clk,
  input logic         rst,
  conv_kxk_stream_if.slave io_bus
);
  localparam int unsigned KK   = KSIZE * KSIZE;
  localparam int unsigned ACCW = conv_accw(BITWIDTH, WBITS, KSIZE);
  localparam int unsigned PW   = BITWIDTH + 1 + WBITS;
  localparam int unsigned CW   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [4:0]    ADDR_LIM = 5'(KK);
  localparam logic signed [ACCW-1:0] PMAX = ACCW'((2 ** BITWIDTH) - 1);
`ifdef CONV_ROUND_EN
  localparam int unsigned RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [ACCW-1:0] RND = (SHIFT > 0) ? (ACCW'(1) << RSH) : '0;
`else
  localparam logic signed [ACCW-1:0] RND = '0;
`endif

  conv_state_e             r_state;
  logic                    r_ready;
  logic signed [WBITS-1:0] r_coef [KK];
  logic [CW-1:0]           r_col;
  logic [RW-1:0]           r_row;
  logic [BITWIDTH-1:0]     r_win [KSIZE][KSIZE];
  logic signed [PW-1:0]    r_prod [KK];
  logic signed [ACCW-1:0]  r_acc;
  logic [BITWIDTH-1:0]     r_dout;
  logic [CONV_LAT-1:0]     r_vld;

  logic                    w_acc;
  logic                    w_win_ok;
  logic [CW-1:0]           w_pcol;
  logic [RW-1:0]           w_prow;
  logic [BITWIDTH-1:0]     w_taps [KSIZE-1];
  logic [BITWIDTH-1:0]     w_col_new [KSIZE];
  logic [BITWIDTH-1:0]     w_win_next [KSIZE][KSIZE];
  logic signed [ACCW-1:0]  w_sum;
  logic signed [ACCW-1:0]  w_rnd;
  logic signed [ACCW-1:0]  w_shr;
  logic [BITWIDTH-1:0]     w_sat;

  assign w_acc    = io_bus.data_in_valid & r_ready;
  // sof pins the accepted pixel to the frame origin.
  assign w_pcol   = io_bus.sof ? '0 : r_col;
  assign w_prow   = io_bus.sof ? '0 : r_row;
  assign w_win_ok = (w_prow >= RW'(KSIZE - 1)) && (w_pcol >= CW'(KSIZE - 1));

  assign io_bus.ready      = r_ready;
  assign io_bus.dout       = r_dout;
  assign io_bus.dout_valid = r_vld[CONV_LAT-1];

  // Control FSM; commit wins over a same-cycle coefficient write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_INIT;
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: if (io_bus.weight_commit) begin
          r_state <= ST_RUN;
          r_ready <= 1'b1;
        end
        ST_RUN: if (io_bus.weight_in_valid && !io_bus.weight_commit) begin
          r_state <= ST_INIT;
          r_ready <= 1'b0;
        end
        default: begin
          r_state <= ST_INIT;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  // Raster position of the next pixel; cleared when a reload leaves RUN.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (r_state == ST_RUN && io_bus.weight_in_valid && !io_bus.weight_commit) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_acc) begin
      if (w_pcol == COL_LAST) begin
        r_col <= '0;
        r_row <= (w_prow == ROW_LAST) ? '0 : w_prow + 1'b1;
      end else begin
        r_col <= w_pcol + 1'b1;
        r_row <= w_prow;
      end
    end
  end

  // Coefficient register file; out-of-range addresses are dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < KK; i++) r_coef[i] <= '0;
    end else if (io_bus.weight_in_valid && io_bus.weight_addr < ADDR_LIM) begin
      r_coef[io_bus.weight_addr] <= io_bus.weight;
    end
  end

  conv_line_buffer #(
    .BITWIDTH (BITWIDTH),
    .COLS     (COLS),
    .DEPTH    (KSIZE - 1)
  ) u_lb (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_acc),
    .i_pix  (io_bus.din),
    .o_taps (w_taps)
  );

  // Window after the current accept: shift left, new column on the right.
  always_comb begin
    w_col_new[KSIZE-1] = io_bus.din;
    for (int unsigned d = 0; d < KSIZE - 1; d++) w_col_new[KSIZE-2-d] = w_taps[d];
    for (int unsigned r = 0; r < KSIZE; r++) begin
      for (int unsigned c = 0; c < KSIZE; c++) begin
        w_win_next[r][c] = (c < KSIZE - 1) ? r_win[r][c+1] : w_col_new[r];
      end
    end
  end

  // Window registers advance only on accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned r = 0; r < KSIZE; r++)
        for (int unsigned c = 0; c < KSIZE; c++) r_win[r][c] <= '0;
    end else if (w_acc) begin
      for (int unsigned r = 0; r < KSIZE; r++)
        for (int unsigned c = 0; c < KSIZE; c++) r_win[r][c] <= w_win_next[r][c];
    end
  end

  // Valid token shifts every clock so in-flight results always drain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_vld <= '0;
    else      r_vld <= {r_vld[CONV_LAT-2:0], w_acc & w_win_ok};
  end

  // Stage 1: products of the just-completed window and current coefficients.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < KK; i++) r_prod[i] <= '0;
    end else if (w_acc) begin
      for (int unsigned r = 0; r < KSIZE; r++)
        for (int unsigned c = 0; c < KSIZE; c++)
          r_prod[r*KSIZE+c] <= PW'($signed({1'b0, w_win_next[r][c]})) * PW'(r_coef[r*KSIZE+c]);
    end
  end

  // Adder tree over sign-extended products.
  always_comb begin
    w_sum = '0;
    for (int unsigned i = 0; i < KK; i++) w_sum = w_sum + ACCW'(r_prod[i]);
  end

  // Stage 2: accumulator register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_acc <= '0;
    else      r_acc <= w_sum;
  end

  // Optional rounding bias, arithmetic shift, clamp to the pixel range.
  always_comb begin
    w_rnd = r_acc + RND;
    w_shr = w_rnd >>> SHIFT;
    if (w_shr[ACCW-1])     w_sat = '0;
    else if (w_shr > PMAX) w_sat = '1;
    else                   w_sat = w_shr[BITWIDTH-1:0];
  end

  // Stage 3: output register, held between pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                r_dout <= '0;
    else if (r_vld[CONV_LAT-2]) r_dout <= w_sat;
  end
endmodule

// File: tb/tb_conv_kxk_stream.sv
// Directed, table-driven bench for conv_kxk_stream (KSIZE=3, 8x6 frame).
module tb_conv_kxk_stream;
  import conv_pkg::*;

  localparam int BW = 8, WB = 9, K = 3, COLS = 8, ROWS = 6, SH = 7;
  localparam int NPIX = COLS * ROWS;
  localparam int NOUT = (ROWS - K + 1) * (COLS - K + 1);

  typedef struct { int stamp; int val; } exp_t;
  typedef struct {
    int    k;     // index of the distinguished coefficient
    int    kv;    // its value
    int    oth;   // value of every other coefficient
    int    pix;   // constant pixel, or -1 for a 0..47 ramp
    int    gap;   // idle cycles after each pixel
    int    expc;  // constant expected output, or -1 for "ramp pixel under tap k"
    string name;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  int   pulses = 0;
  int unsigned cyc = 0;
  logic [BW-1:0] last_dout = '0;
  exp_t expq[$];
  vec_t tbl[9];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  conv_kxk_stream_if #(.BITWIDTH(BW), .WBITS(WB)) bus ();

  conv_kxk_stream #(
    .BITWIDTH (BW),
    .WBITS    (WB),
    .KSIZE    (K),
    .COLS     (COLS),
    .ROWS     (ROWS),
    .SHIFT    (SH)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Output monitor: every pulse must match the head of the expectation queue.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      last_dout = '0;
    end else if (bus.dout_valid) begin
      pulses++;
      if (expq.size() == 0) begin
        check("stray_pulse", 1, 0);
      end else begin
        e = expq.pop_front();
        check("dout_value", int'(bus.dout), e.val);
        check("dout_latency", int'(cyc), e.stamp);
      end
      last_dout = bus.dout;
    end else begin
      check("dout_hold", int'(bus.dout), int'(last_dout));
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.data_in_valid   = 1'b0;
      bus.sof             = 1'b0;
      bus.weight_in_valid = 1'b0;
      bus.weight_commit   = 1'b0;
    end
  endtask

  task automatic load_kernel(input int k, input int kv, input int oth);
    @(negedge clk);
    bus.data_in_valid   = 1'b0;
    bus.weight_in_valid = 1'b1;
    bus.weight_addr     = 5'd12;
    bus.weight          = WB'(-128);
    for (int i = 0; i < K * K; i++) begin
      @(negedge clk);
      bus.weight_in_valid = 1'b1;
      bus.weight_addr     = 5'(i);
      bus.weight          = WB'((i == k) ? kv : oth);
      bus.weight_commit   = (i == K * K - 1);
    end
    @(negedge clk);
    bus.weight_in_valid = 1'b0;
    bus.weight_commit   = 1'b0;
    check("ready_after_commit", int'(bus.ready), 1);
  endtask

  task automatic stream(input vec_t v, input int npix);
    int r, c, tr, tc, ev;
    for (int p = 0; p < npix; p++) begin
      r = p / COLS;
      c = p % COLS;
      @(negedge clk);
      bus.data_in_valid = 1'b1;
      bus.sof           = (p == 0);
      bus.din           = BW'((v.pix < 0) ? p : v.pix);
      if (r >= K - 1 && c >= K - 1) begin
        tr = r - (K - 1) + v.k / K;
        tc = c - (K - 1) + v.k % K;
        ev = (v.expc >= 0) ? v.expc : COLS * tr + tc;
        expq.push_back('{int'(cyc) + int'(CONV_LAT), ev});
      end
      for (int g = 0; g < v.gap; g++) begin
        @(negedge clk);
        bus.data_in_valid = 1'b0;
        bus.sof           = 1'b0;
        bus.din           = 8'hAA;
      end
    end
    @(negedge clk);
    bus.data_in_valid = 1'b0;
    bus.sof           = 1'b0;
  endtask

  task automatic run_frame(input vec_t v);
    int start;
    start = pulses;
    stream(v, NPIX);
    idle(6);
    check({v.name, "_count"}, pulses - start, NOUT);
    check({v.name, "_drained"}, expq.size(), 0);
  endtask

  initial begin
    int start;
    vec_t v0;
    vec_t vz;

    tbl[0] = '{4, 128, 0, -1, 0, -1, "ramp_centre"};
    tbl[1] = '{0, 128, 0, -1, 0, -1, "ramp_topleft"};
    tbl[2] = '{8, 128, 0, -1, 0, -1, "ramp_botright"};
    tbl[3] = '{5, 128, 0, -1, 0, -1, "ramp_midright"};
    tbl[4] = '{4, 128, 0, -1, 2, -1, "ramp_gapped"};
    tbl[5] = '{0, 127, 127, 255, 0, 255, "sat_high"};
    tbl[6] = '{0, -128, -128, 10, 0, 0, "sat_low"};
    tbl[7] = '{4, 128, 8, 100, 0, 150, "mixed_sum"};
`ifdef CONV_ROUND_EN
    tbl[8] = '{4, 64, 0, 3, 0, 2, "round"};
`else
    tbl[8] = '{4, 64, 0, 3, 0, 1, "round"};
`endif
    v0 = tbl[0];
    vz = '{4, 0, 0, -1, 0, 0, "after_reset"};

    bus.weight_in_valid = 1'b0;
    bus.weight_addr     = '0;
    bus.weight          = '0;
    bus.weight_commit   = 1'b0;
    bus.data_in_valid   = 1'b0;
    bus.sof             = 1'b0;
    bus.din             = '0;

    // Reset state.
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_ready", int'(bus.ready), 0);
    check("reset_dout", int'(bus.dout), 0);
    check("reset_dout_valid", int'(bus.dout_valid), 0);
    rst = 1'b1;

    // INIT ignores pixels.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.data_in_valid = 1'b1;
      bus.sof           = (i == 0);
      bus.din           = 8'd50;
      check("init_ready_low", int'(bus.ready), 0);
    end
    idle(5);

    // Table-driven frames.
    foreach (tbl[i]) begin
      load_kernel(tbl[i].k, tbl[i].kv, tbl[i].oth);
      run_frame(tbl[i]);
    end

    // Mid-frame coefficient write: in-flight results drain, then pixels are ignored.
    load_kernel(4, 128, 0);
    start = pulses;
    stream(v0, 21);
    bus.weight_in_valid = 1'b1;
    bus.weight_addr     = 5'd4;
    bus.weight          = WB'(128);
    check("ready_during_write", int'(bus.ready), 1);
    @(negedge clk);
    bus.weight_in_valid = 1'b0;
    check("ready_drop", int'(bus.ready), 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.data_in_valid = 1'b1;
      bus.sof           = (i == 0);
      bus.din           = 8'd200;
    end
    idle(4);
    check("midframe_drain_count", pulses - start, 3);
    @(negedge clk);
    bus.weight_commit = 1'b1;
    @(negedge clk);
    bus.weight_commit = 1'b0;
    check("ready_recommit", int'(bus.ready), 1);
    run_frame(v0);

    // Reset after pixel 30: immediate clear, in-flight results flushed.
    load_kernel(4, 128, 0);
    stream(v0, 31);
    @(posedge clk);
    #2;
    rst = 1'b0;
    expq.delete();
    #1;
    check("midreset_dout", int'(bus.dout), 0);
    check("midreset_dout_valid", int'(bus.dout_valid), 0);
    check("midreset_ready", int'(bus.ready), 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    start = pulses;
    idle(8);
    check("postreset_no_pulse", pulses - start, 0);
    check("postreset_ready", int'(bus.ready), 0);
    @(negedge clk);
    bus.weight_commit = 1'b1;
    @(negedge clk);
    bus.weight_commit = 1'b0;
    check("postreset_commit_ready", int'(bus.ready), 1);
    run_frame(vz);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
